// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: default sizing
// parameters and the loader FSM state encoding.
package instr_mem_loader_pkg;

  localparam int INSTR_W_DEF      = 32;    // instruction width, multiple of 8
  localparam int INSTR_ADDR_W_DEF = 10;    // instruction word address width
  localparam int NUM_INSTRS_DEF   = 1024;  // instruction store depth in words

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Byte-to-word assembler for the instruction loader.
// Collects INSTR_W/8 bytes little-endian (first byte in bits [7:0]).
// Ports:
//   CLOCK_50   rising-edge clock
//   reset_n    synchronous active-low reset
//   clear      restart assembly of a new word (byte counter, full flag)
//   byte_take  a byte transfers this cycle
//   byte_data  the byte being transferred
//   last_byte  this transfer completes the word (combinational)
//   word_full  a complete word is held in word
//   word       assembled instruction word
module word_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               byte_take,
  input  logic [7:0]         byte_data,
  output logic               last_byte,
  output logic               word_full,
  output logic [INSTR_W-1:0] word
);

  localparam int NB = INSTR_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] byte_cnt;

  assign last_byte = byte_take && (byte_cnt == CW'(NB - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      byte_cnt  <= '0;
      word_full <= 1'b0;
      word      <= '0;
    end else if (clear) begin
      byte_cnt  <= '0;
      word_full <= 1'b0;
    end else if (byte_take) begin
      // Shift in from the top: after NB bytes the first one sits in [7:0].
      word <= (INSTR_W'(byte_data) << (INSTR_W - 8)) | (word >> 8);
      if (last_byte) begin
        byte_cnt  <= '0;
        word_full <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a program as a byte stream, packs it
// into instruction words and writes them to the instruction store at
// consecutive addresses starting from 0.
// Ports:
//   CLOCK_50      rising-edge clock
//   reset_n       synchronous active-low reset
//   start         one-cycle pulse, begins a load (ignored while busy)
//   load_len      words to load; 0 or > NUM_INSTRS means NUM_INSTRS
//   byte_valid    incoming program byte present
//   byte_data     incoming program byte
//   byte_ready    loader accepts a byte this cycle
//   wr_req        write request toward the instruction store
//   wr_addr       word address of the write
//   wr_data       instruction word to write
//   wr_ack        store accepts the write this cycle
//   load_busy     load in progress (fetch stage held off)
//   load_done     last load completed (level)
//   words_loaded  words written in the current/last load
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int INSTR_W      = INSTR_W_DEF,
  parameter int INSTR_ADDR_W = INSTR_ADDR_W_DEF,
  parameter int NUM_INSTRS   = NUM_INSTRS_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [INSTR_ADDR_W:0]   load_len,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    wr_req,
  output logic [INSTR_ADDR_W-1:0] wr_addr,
  output logic [INSTR_W-1:0]      wr_data,
  input  logic                    wr_ack,
  output logic                    load_busy,
  output logic                    load_done,
  output logic [INSTR_ADDR_W:0]   words_loaded
);

  localparam int                LEN_W    = INSTR_ADDR_W + 1;
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(NUM_INSTRS);

  loader_state_t    state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_q;
  logic             start_ok;
  logic             byte_take;
  logic             write_done;
  logic             last_byte;
  logic             word_full;
  logic [INSTR_W-1:0] word;

  // Handshake outputs are plain state decodes so the byte/write handshake
  // does not loop back through the next-state logic.
  assign byte_ready = (state == COLLECT);
  // word_full is always set in WRITE; gating keeps a stray write impossible.
  assign wr_req     = (state == WRITE) && word_full;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign byte_take  = byte_valid && byte_ready;
  assign write_done = wr_req && wr_ack;

  assign wr_addr      = words_q[INSTR_ADDR_W-1:0];
  assign wr_data      = word;
  assign words_loaded = words_q;

  word_assembler #(
    .INSTR_W (INSTR_W)
  ) u_word_assembler (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .clear     (start_ok || write_done),
    .byte_take (byte_take),
    .byte_data (byte_data),
    .last_byte (last_byte),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_busy = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        load_busy = 1'b1;
        if (last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        load_busy = 1'b1;
        if (write_done) begin
          state_nxt = ((words_q + 1'b1) == len_q) ? DONE : COLLECT;
        end
      end
      DONE: begin
        load_done = 1'b1;
        if (start) state_nxt = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      len_q   <= '0;
      words_q <= '0;
    end else if (start_ok) begin
      words_q <= '0;
      len_q   <= ((load_len == '0) || (load_len > FULL_LEN)) ? FULL_LEN : load_len;
    end else if (write_done) begin
      words_q <= words_q + 1'b1;
    end
  end

endmodule
